// File: rtl/noc_vc_split_pkg.sv
// Shared NoC flit layout: data width, VC/buffer defaults, flit-type encoding and field positions.
package Noc_parameters;

  localparam int unsigned Noc_Data_Width      = 32;
  localparam int unsigned Noc_VC_Channel      = 4;
  localparam int unsigned Noc_VC_Fifo_Depth   = 4;

  localparam int unsigned Noc_Flit_Type_Lsb   = 30;
  localparam int unsigned Noc_Flit_Type_Width = 2;
  localparam int unsigned Noc_VC_Id_Lsb       = 26;
  localparam int unsigned Noc_VC_Id_Width     = 4;

  typedef enum logic [Noc_Flit_Type_Width-1:0] {
    FLIT_HEAD      = 2'd0,
    FLIT_BODY      = 2'd1,
    FLIT_TAIL      = 2'd2,
    FLIT_HEAD_TAIL = 2'd3
  } noc_flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_PACKET = 1'b1
  } noc_split_state_e;

  function automatic noc_flit_type_e noc_flit_type(input logic [Noc_Data_Width-1:0] flit);
    return noc_flit_type_e'(flit[Noc_Flit_Type_Lsb +: Noc_Flit_Type_Width]);
  endfunction

  function automatic logic [Noc_VC_Id_Width-1:0] noc_flit_vc(input logic [Noc_Data_Width-1:0] flit);
    return flit[Noc_VC_Id_Lsb +: Noc_VC_Id_Width];
  endfunction

endpackage

// File: rtl/noc_vc_split_fifo.sv
// Single-VC flit buffer: circular storage (any depth), occupancy count and registered below-threshold flag.
module noc_vc_split_fifo
  import Noc_parameters::*;
#(
  parameter int unsigned DEPTH     = Noc_VC_Fifo_Depth,
  parameter int unsigned THRESHOLD = Noc_VC_Fifo_Depth - 2,
  parameter int unsigned WIDTH     = Noc_Data_Width
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             below_thr_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] THR_CNT  = CW'(THRESHOLD);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             below_q;
  logic             wr, rd;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == FULL_CNT);
  assign rd_data_o   = mem_q[rd_ptr_q];
  assign below_thr_o = below_q;

  // Full refuses the write even when a pop happens in the same cycle.
  always_comb begin
    wr      = wr_en_i & ~full_o;
    rd      = rd_en_i & ~empty_o;
    count_d = count_q;
    unique case ({wr, rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      below_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      below_q <= (count_d < THR_CNT);
      if (wr) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (rd) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/noc_vc_split.sv
// Demultiplexes a wormhole flit stream onto per-VC buffers, tracking packet framing and dropping malformed flits.
module noc_vc_split
  import Noc_parameters::*;
#(
  parameter int unsigned CHANNELS  = Noc_VC_Channel,
  parameter int unsigned DEPTH     = Noc_VC_Fifo_Depth,
  parameter int unsigned THRESHOLD = Noc_VC_Fifo_Depth - 2
) (
  input  logic                                     noc_clk,
  input  logic                                     noc_rst_n,
  input  logic                                     i_clear,
  input  logic                                     i_valid,
  output logic                                     o_ready,
  input  logic [Noc_Data_Width-1:0]                i_flit,
  output logic [CHANNELS-1:0]                      o_vc_ready,
  output logic [CHANNELS-1:0]                      o_valid,
  input  logic [CHANNELS-1:0]                      i_ready,
  output logic [CHANNELS-1:0][Noc_Data_Width-1:0]  o_flit,
  output logic                                     o_drop
);

  localparam int unsigned VCW = $clog2(CHANNELS);

  noc_split_state_e     state_q;
  logic [VCW-1:0]       cur_vc_q;
  logic                 drop_q;

  noc_flit_type_e       ftype;
  logic [Noc_VC_Id_Width-1:0] vcid;
  logic [VCW-1:0]       tgt;
  logic                 malformed;
  logic                 accept;
  logic [CHANNELS-1:0]  wr_vec, full_vec, empty_vec;

  assign ftype = noc_flit_type(i_flit);
  assign vcid  = noc_flit_vc(i_flit);

  // Out-of-range VC-ids are only checked in IDLE; mid-packet the header VC-id field is not consulted.
  always_comb begin
    malformed = 1'b0;
    tgt       = cur_vc_q;
    if (state_q == ST_IDLE) begin
      tgt       = VCW'(vcid);
      malformed = (ftype == FLIT_BODY) || (ftype == FLIT_TAIL) || (32'(vcid) >= CHANNELS);
    end else begin
      malformed = (ftype == FLIT_HEAD) || (ftype == FLIT_HEAD_TAIL);
    end
  end

  assign o_ready = noc_rst_n & (malformed | ~full_vec[tgt]);
  assign accept  = i_valid & o_ready & ~i_clear;
  assign o_drop  = drop_q;

  always_comb begin
    wr_vec = '0;
    if (accept && !malformed) wr_vec[tgt] = 1'b1;
  end

  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n || i_clear) begin
      state_q  <= ST_IDLE;
      cur_vc_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= accept & malformed;
      if (accept && !malformed) begin
        unique case (state_q)
          ST_IDLE: begin
            if (ftype == FLIT_HEAD) begin
              state_q  <= ST_PACKET;
              cur_vc_q <= tgt;
            end
          end
          ST_PACKET: begin
            if (ftype == FLIT_TAIL) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
    noc_vc_split_fifo #(
      .DEPTH     (DEPTH),
      .THRESHOLD (THRESHOLD),
      .WIDTH     (Noc_Data_Width)
    ) u_fifo (
      .clk_i       (noc_clk),
      .rst_ni      (noc_rst_n),
      .clear_i     (i_clear),
      .wr_en_i     (wr_vec[v]),
      .wr_data_i   (i_flit),
      .rd_en_i     (o_valid[v] & i_ready[v]),
      .rd_data_o   (o_flit[v]),
      .empty_o     (empty_vec[v]),
      .full_o      (full_vec[v]),
      .below_thr_o (o_vc_ready[v])
    );
    assign o_valid[v] = ~empty_vec[v];
  end

endmodule

// File: tb/tb_noc_vc_split.sv
// Scoreboard bench for noc_vc_split: per-VC expected-flit queues plus a packet-framing model.
module tb_noc_vc_split;
  import Noc_parameters::*;

  localparam int CH = 4;
  localparam int DP = 4;
  localparam int TH = 2;

  logic                               clk;
  logic                               rst_n;
  logic                               clear;
  logic                               i_valid;
  logic                               o_ready;
  logic [Noc_Data_Width-1:0]          i_flit;
  logic [CH-1:0]                      o_vc_ready;
  logic [CH-1:0]                      o_valid;
  logic [CH-1:0]                      i_ready;
  logic [CH-1:0][Noc_Data_Width-1:0]  o_flit;
  logic                               o_drop;

  noc_vc_split #(
    .CHANNELS  (CH),
    .DEPTH     (DP),
    .THRESHOLD (TH)
  ) dut (
    .noc_clk    (clk),
    .noc_rst_n  (rst_n),
    .i_clear    (clear),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_flit     (i_flit),
    .o_vc_ready (o_vc_ready),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_flit     (o_flit),
    .o_drop     (o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [Noc_Data_Width-1:0] sb [CH][$];
  logic        m_pkt  = 1'b0;
  int unsigned m_cur  = 0;
  logic        m_drop = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [Noc_Data_Width-1:0] mk(input noc_flit_type_e t, input int unsigned vc,
                                                     input int unsigned pl);
    logic [Noc_Data_Width-1:0] f;
    f = '0;
    f[Noc_Flit_Type_Lsb +: Noc_Flit_Type_Width] = t;
    f[Noc_VC_Id_Lsb +: Noc_VC_Id_Width]         = vc[Noc_VC_Id_Width-1:0];
    f[15:0]                                      = pl[15:0];
    return f;
  endfunction

  // One clock cycle: check combinational outputs before the edge, advance the model, check registered outputs after.
  task automatic step();
    noc_flit_type_e ft;
    int unsigned    vid, tgt;
    logic           mal, rdy, acc;
    #1;
    ft  = noc_flit_type_e'(i_flit[Noc_Flit_Type_Lsb +: Noc_Flit_Type_Width]);
    vid = 32'(i_flit[Noc_VC_Id_Lsb +: Noc_VC_Id_Width]);
    if (!m_pkt) begin
      mal = (ft == FLIT_BODY) || (ft == FLIT_TAIL) || (vid >= CH);
      tgt = vid;
    end else begin
      mal = (ft == FLIT_HEAD) || (ft == FLIT_HEAD_TAIL);
      tgt = m_cur;
    end
    if (mal) rdy = 1'b1;
    else     rdy = (sb[tgt].size() < DP);
    rdy = rdy && rst_n;
    if (!clear) check("o_ready", o_ready, rdy);
    if (rst_n) begin
      for (int v = 0; v < CH; v++) begin
        check($sformatf("o_valid[%0d]", v), o_valid[v], sb[v].size() > 0);
        if (sb[v].size() > 0) check($sformatf("o_flit[%0d]", v), o_flit[v], sb[v][0]);
      end
    end
    acc = i_valid && rdy && !clear && rst_n;
    @(posedge clk);
    if (!rst_n || clear) begin
      for (int v = 0; v < CH; v++) sb[v].delete();
      m_pkt  = 1'b0;
      m_cur  = 0;
      m_drop = 1'b0;
    end else begin
      for (int v = 0; v < CH; v++)
        if (i_ready[v] && sb[v].size() > 0) void'(sb[v].pop_front());
      m_drop = acc && mal;
      if (acc && !mal) begin
        sb[tgt].push_back(i_flit);
        if (!m_pkt && ft == FLIT_HEAD) begin
          m_pkt = 1'b1;
          m_cur = tgt;
        end else if (m_pkt && ft == FLIT_TAIL) begin
          m_pkt = 1'b0;
        end
      end
    end
    #1;
    check("o_drop", o_drop, m_drop);
    for (int v = 0; v < CH; v++)
      check($sformatf("o_vc_ready[%0d]", v), o_vc_ready[v], sb[v].size() < TH);
  endtask

  task automatic send(input noc_flit_type_e t, input int unsigned vc, input int unsigned pl);
    i_valid = 1'b1;
    i_flit  = mk(t, vc, pl);
    step();
  endtask

  task automatic idle(input int unsigned n);
    i_valid = 1'b0;
    for (int unsigned k = 0; k < n; k++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    clear   = 1'b0;
    i_valid = 1'b1;
    i_flit  = mk(FLIT_HEAD, 1, 16'h0bad);
    i_ready = '1;
    step();
    step();
    rst_n = 1'b1;
    idle(2);

    // Three-flit packet on VC2, then a single-flit packet proves return to IDLE.
    send(FLIT_HEAD, 2, 16'h0100);
    send(FLIT_BODY, 0, 16'h0101);
    send(FLIT_TAIL, 0, 16'h0102);
    send(FLIT_HEAD_TAIL, 0, 16'h0103);
    idle(3);

    // VC1 stalled: threshold and full backpressure, then drain in order.
    i_ready = 4'b1101;
    for (int unsigned k = 0; k < 5; k++) send(FLIT_HEAD_TAIL, 1, 16'h0200 + k);
    i_ready = '1;
    step();
    step();
    idle(6);

    // Malformed flits: BODY in IDLE, HEAD inside a packet, out-of-range VC-id.
    send(FLIT_BODY, 0, 16'h0300);
    send(FLIT_HEAD, 0, 16'h0301);
    send(FLIT_HEAD, 3, 16'h0302);
    send(FLIT_TAIL, 3, 16'h0303);
    send(FLIT_HEAD, 9, 16'h0304);
    send(FLIT_HEAD_TAIL, 7, 16'h0305);
    idle(3);

    // Full VC0 with a concurrent pop: refused once, accepted on the retry.
    i_ready = 4'b1110;
    for (int unsigned k = 0; k < 4; k++) send(FLIT_HEAD_TAIL, 0, 16'h0400 + k);
    i_ready = '1;
    send(FLIT_HEAD_TAIL, 0, 16'h0404);
    step();
    idle(6);

    // Clear in the middle of a VC3 packet.
    i_ready = 4'b0111;
    send(FLIT_HEAD, 3, 16'h0500);
    send(FLIT_BODY, 0, 16'h0501);
    clear = 1'b1;
    send(FLIT_BODY, 0, 16'h0502);
    clear = 1'b0;
    i_ready = '1;
    send(FLIT_BODY, 0, 16'h0503);
    send(FLIT_HEAD, 3, 16'h0504);
    send(FLIT_TAIL, 0, 16'h0505);
    idle(3);

    // Reset in the middle of a VC3 packet.
    i_ready = 4'b0111;
    send(FLIT_HEAD, 3, 16'h0600);
    send(FLIT_BODY, 0, 16'h0601);
    rst_n = 1'b0;
    send(FLIT_BODY, 0, 16'h0602);
    rst_n = 1'b1;
    i_ready = '1;
    send(FLIT_BODY, 0, 16'h0603);
    send(FLIT_HEAD, 3, 16'h0604);
    send(FLIT_TAIL, 0, 16'h0605);
    idle(3);

    // Random traffic including drops, stalls and occasional clears.
    for (int unsigned k = 0; k < 400; k++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_flit  = mk(noc_flit_type_e'($urandom_range(0, 3)), $urandom_range(0, 5), 16'h1000 + k);
      i_ready = 4'($urandom_range(0, 15));
      clear   = ($urandom_range(0, 49) == 0);
      step();
    end
    clear   = 1'b0;
    i_ready = '1;
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/noc_vc_split.md
NOC_VC_SPLIT -- requirements
Module: noc_vc_split

Interface
REQ-001 Parameter CHANNELS, default Noc_VC_Channel, number of virtual channels (>=2).
REQ-002 Parameter DEPTH, default Noc_VC_Fifo_Depth, per-VC buffer depth in flits (>=2).
REQ-003 Parameter THRESHOLD, default Noc_VC_Fifo_Depth-2, per-VC occupancy at which vc_ready deasserts (1..DEPTH).
REQ-004 noc_clk  input  1  single clock; all logic on rising edge.
REQ-005 noc_rst_n  input  1  reset, synchronous and active-low.
REQ-006 i_clear  input  1  synchronous flush of all buffers and packet state.
REQ-007 i_valid  input  1  upstream flit valid.
REQ-008 o_ready  output  1  flit accepted this cycle when i_valid and o_ready are both high.
REQ-009 i_flit  input  Noc_Data_Width  upstream flit; type and VC-id fields at package-defined positions.
REQ-010 o_vc_ready  output  CHANNELS  per-VC backpressure hint to upstream arbiter.
REQ-011 o_valid  output  CHANNELS  per-VC downstream flit valid.
REQ-012 i_ready  input  CHANNELS  per-VC downstream ready.
REQ-013 o_flit  output  CHANNELS x Noc_Data_Width  per-VC head-of-buffer flit.
REQ-014 o_drop  output  1  one-cycle pulse: accepted flit discarded as malformed.

Function
REQ-015 Flit type field: HEAD, BODY, TAIL, HEAD_TAIL; VC-id field meaningful only in HEAD/HEAD_TAIL flits.
REQ-016 FSM states IDLE, PACKET; register cur_vc of $clog2(CHANNELS) bits.
REQ-017 IDLE: target VC = VC-id of i_flit; PACKET: target VC = cur_vc.
REQ-018 o_ready = target buffer not full, except o_ready=1 for any flit that will be dropped.
REQ-019 IDLE + accepted HEAD with valid VC-id -> write, cur_vc <= VC-id, go PACKET.
REQ-020 IDLE + accepted HEAD_TAIL with valid VC-id -> write, stay IDLE.
REQ-021 PACKET + accepted BODY -> write to cur_vc, stay PACKET; accepted TAIL -> write, go IDLE.
REQ-022 Drop (no write, o_drop pulse next cycle, state unchanged): BODY/TAIL in IDLE; HEAD/HEAD_TAIL in PACKET; VC-id >= CHANNELS.
REQ-023 Written flit appears on o_flit[v] with o_valid[v]=1 the cycle after acceptance (latency 1); flit stored unmodified.
REQ-024 Per-VC FIFO order preserved; o_flit[v] stable while o_valid[v]=1 and i_ready[v]=0.
REQ-025 Pop on o_valid[v]&i_ready[v]; count width $clog2(DEPTH+1); count +1 write-only, -1 read-only, unchanged on simultaneous read and write.
REQ-026 Full buffer: write refused (o_ready=0) even if a read occurs the same cycle; no bypass.
REQ-027 Empty buffer: o_valid[v]=0, o_flit[v] don't-care; no read-through of the same-cycle write.
REQ-028 o_vc_ready[v] = registered (count[v] < THRESHOLD), updated each cycle from next-state count.
REQ-029 Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
REQ-030 i_clear=1: all counts/pointers zeroed, FSM to IDLE, input flit that cycle not written, o_drop=0; i_clear has priority over traffic.

Reset
REQ-031 noc_rst_n=0 at a clock edge: FSM IDLE, cur_vc=0, all counts/pointers 0, o_valid=0, o_drop=0, o_vc_ready all 1.
REQ-032 o_ready during reset = 0; buffer data storage not reset.
REQ-033 Reset mid-packet discards buffered flits and partial-packet state; the first flit after reset is treated in IDLE.

Structure
REQ-034 Noc_parameters holds flit-type enum, type-field and VC-id-field LSB/width constants; none are local to this module.
REQ-035 One sub-module noc_vc_split_fifo (single-VC buffer with count, full, empty, threshold flag), instantiated CHANNELS times in a generate loop.

Verification (CHANNELS=4, DEPTH=4, THRESHOLD=2)
REQ-036 HEAD vc=2, BODY, TAIL back-to-back, i_ready=all 1 -> three flits on o_flit[2] in cycles 1..3, other VCs idle, FSM returns IDLE.
REQ-037 i_ready[1]=0, 4 HEAD_TAIL to vc=1 -> o_vc_ready[1] low after 2nd write, o_ready low on 5th flit; raise i_ready[1] -> 4 flits out in order, o_ready reasserts.
REQ-038 BODY in IDLE, then HEAD vc=0 + HEAD vc=3 -> o_drop pulses for BODY and second HEAD; only first HEAD reaches o_flit[0].
REQ-039 Full vc=0 with simultaneous pop and new write -> write refused that cycle, count 4->3, write accepted next cycle.
REQ-040 Mid-packet on vc=3 with 2 flits buffered, assert i_clear (then separately noc_rst_n=0) -> o_valid=0, o_vc_ready=4'hF, next BODY dropped, next HEAD accepted.
